// File: rtl/sp_pkg.sv
// Shared types and helpers for the self-purging replica voter.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package sp_pkg;

  localparam int SP_W_DEF   = 32;
  localparam int SP_N_DEF   = 6;
  localparam int SP_THR_DEF = 4;

  typedef enum logic [0:0] {
    SP_RUN    = 1'b0,
    SP_FAILED = 1'b1
  } sp_state_e;

  // Callers zero-extend their vector, so replica counts are limited to 64.
  function automatic int sp_popcount(input logic [63:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      cnt += int'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sp_bit_vote.sv
// One-bit threshold gate over N replica bits, with purged replicas forced to 0.
// Latency: combinational.
// Backpressure: none.
module sp_bit_vote
  import sp_pkg::*;
#(
  parameter int N   = SP_N_DEF,
  parameter int THR = SP_THR_DEF
) (
  input  logic [N-1:0] i_bits,
  input  logic [N-1:0] i_mask,
  output logic         o_vote
);

  logic [N-1:0] w_masked;

  assign w_masked = i_bits & i_mask;
  assign o_vote   = (sp_popcount(64'(w_masked)) >= THR);

endmodule

// File: rtl/sp_purge_voter.sv
// Votes N replica words, purges dissenting replicas and flags failure below THR active; build with SP_PURGE_HOLDOFF_EN for 2-strike purging.
// Latency: 1 cycle from in_valid to out_valid/voted_data.
// Backpressure: none; a sample is accepted every cycle in_valid is high.
module sp_purge_voter
  import sp_pkg::*;
#(
  parameter int W   = SP_W_DEF,
  parameter int N   = SP_N_DEF,
  parameter int THR = SP_THR_DEF,
  parameter int CW  = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           arm,
  input  logic           in_valid,
  input  logic [N*W-1:0] rep_data,
  output logic           out_valid,
  output logic [W-1:0]   voted_data,
  output logic [N-1:0]   active_mask,
  output logic [CW-1:0]  active_cnt,
  output logic           purge_event,
  output logic           fail
);

  logic           r_out_valid;
  logic [W-1:0]   r_voted;
  logic [N-1:0]   r_active_mask;
  logic [CW-1:0]  r_active_cnt;
  logic           r_purge_event;
  sp_state_e      r_state;

  logic [N-1:0]   w_vote_mask;
  logic [W-1:0]   w_vote;
  logic [N-1:0]   w_mismatch;
  logic [N-1:0]   w_purge;
  logic           w_purge_ok;
  logic [N-1:0]   w_mask_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  sp_state_e      w_state_nxt;

  // arm re-enables every replica for the sample arriving in the same cycle.
  assign w_vote_mask = arm ? {N{1'b1}} : r_active_mask;

  for (genvar b = 0; b < W; b++) begin : g_bit
    logic [N-1:0] w_col;
    for (genvar i = 0; i < N; i++) begin : g_rep
      assign w_col[i] = rep_data[i*W + b];
    end
    sp_bit_vote #(
      .N   (N),
      .THR (THR)
    ) u_bit_vote (
      .i_bits (w_col),
      .i_mask (w_vote_mask),
      .o_vote (w_vote[b])
    );
  end

  always_comb begin
    w_mismatch = '0;
    for (int i = 0; i < N; i++) begin
      w_mismatch[i] = r_active_mask[i] && (rep_data[i*W +: W] != w_vote);
    end
  end

  assign w_purge_ok = in_valid && !arm && (r_state == SP_RUN);

`ifdef SP_PURGE_HOLDOFF_EN
  logic [N-1:0][1:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_cnt <= '0;
    end else if (arm) begin
      r_miss_cnt <= '0;
    end else if (w_purge_ok) begin
      for (int i = 0; i < N; i++) begin
        if (!w_mismatch[i]) begin
          r_miss_cnt[i] <= 2'd0;
        end else if (r_miss_cnt[i] != 2'd3) begin
          r_miss_cnt[i] <= r_miss_cnt[i] + 2'd1;
        end
      end
    end
  end

  // A nonzero counter means the previous valid sample also mismatched.
  always_comb begin
    w_purge = '0;
    for (int i = 0; i < N; i++) begin
      w_purge[i] = w_purge_ok && w_mismatch[i] && (r_miss_cnt[i] != 2'd0);
    end
  end
`else
  assign w_purge = w_mismatch & {N{w_purge_ok}};
`endif

  always_comb begin
    w_mask_nxt  = arm ? {N{1'b1}} : (r_active_mask & ~w_purge);
    w_cnt_nxt   = CW'(sp_popcount(64'(w_mask_nxt)));
    w_state_nxt = r_state;
    if (arm) begin
      w_state_nxt = SP_RUN;
    end else if ((r_state == SP_RUN) && (int'(w_cnt_nxt) < THR)) begin
      w_state_nxt = SP_FAILED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_voted       <= '0;
      r_active_mask <= {N{1'b1}};
      r_active_cnt  <= CW'(N);
      r_purge_event <= 1'b0;
      r_state       <= SP_RUN;
    end else begin
      r_out_valid   <= in_valid;
      if (in_valid) begin
        r_voted <= w_vote;
      end
      r_active_mask <= w_mask_nxt;
      r_active_cnt  <= w_cnt_nxt;
      r_purge_event <= |w_purge;
      r_state       <= w_state_nxt;
    end
  end

  assign out_valid   = r_out_valid;
  assign voted_data  = r_voted;
  assign active_mask = r_active_mask;
  assign active_cnt  = r_active_cnt;
  assign purge_event = r_purge_event;
  assign fail        = (r_state == SP_FAILED);

endmodule

// File: tb/tb_sp_purge_voter.sv
// Directed vector bench for sp_purge_voter at W=8, N=6, THR=4.
// Vectors are driven on the falling edge and checked 1 ns after the rising edge.
module tb_sp_purge_voter;

  localparam int W   = 8;
  localparam int N   = 6;
  localparam int THR = 4;
  localparam int CW  = 3;

  logic           clk;
  logic           rst_n;
  logic           arm;
  logic           in_valid;
  logic [N*W-1:0] rep_data;
  logic           out_valid;
  logic [W-1:0]   voted_data;
  logic [N-1:0]   active_mask;
  logic [CW-1:0]  active_cnt;
  logic           purge_event;
  logic           fail;

  sp_purge_voter #(
    .W   (W),
    .N   (N),
    .THR (THR),
    .CW  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .in_valid    (in_valid),
    .rep_data    (rep_data),
    .out_valid   (out_valid),
    .voted_data  (voted_data),
    .active_mask (active_mask),
    .active_cnt  (active_cnt),
    .purge_event (purge_event),
    .fail        (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           arm;
    logic           vld;
    logic [N*W-1:0] rep;
    logic           ov;
    logic [W-1:0]   vd;
    logic [N-1:0]   mask;
    logic [CW-1:0]  cnt;
    logic           pe;
    logic           fl;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_mis;

  function automatic logic [N*W-1:0] pack6(input logic [7:0] r0, input logic [7:0] r1,
                                           input logic [7:0] r2, input logic [7:0] r3,
                                           input logic [7:0] r4, input logic [7:0] r5);
    return {r5, r4, r3, r2, r1, r0};
  endfunction

  function automatic vec_t mk(input logic a, input logic v, input logic [N*W-1:0] r,
                              input logic ov, input logic [W-1:0] vd, input logic [N-1:0] m,
                              input logic [CW-1:0] c, input logic pe, input logic fl);
    vec_t t;
    t.arm = a; t.vld = v; t.rep = r;
    t.ov = ov; t.vd = vd; t.mask = m; t.cnt = c; t.pe = pe; t.fl = fl;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic ov, input logic [W-1:0] vd,
                               input logic [N-1:0] m, input logic [CW-1:0] c,
                               input logic pe, input logic fl);
    n_vec++;
    chk("out_valid",   idx, 32'(out_valid),   32'(ov));
    chk("voted_data",  idx, 32'(voted_data),  32'(vd));
    chk("active_mask", idx, 32'(active_mask), 32'(m));
    chk("active_cnt",  idx, 32'(active_cnt),  32'(c));
    chk("purge_event", idx, 32'(purge_event), 32'(pe));
    chk("fail",        idx, 32'(fail),        32'(fl));
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    arm      = v.arm;
    in_valid = v.vld;
    rep_data = v.rep;
    @(posedge clk);
    #1;
    check_outputs(idx, v.ov, v.vd, v.mask, v.cnt, v.pe, v.fl);
  endtask

  initial begin
    n_vec    = 0;
    n_mis    = 0;
    rst_n    = 1'b0;
    arm      = 1'b0;
    in_valid = 1'b0;
    rep_data = '0;

`ifdef SP_PURGE_HOLDOFF_EN
    // Replica 5: miss, match, miss, miss -> purged only on the second consecutive miss.
    vecs.push_back(mk(0, 1, pack6(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5), 1, 8'hA5, 6'h3F, 3'd6, 0, 0));
    vecs.push_back(mk(0, 1, pack6(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00), 1, 8'hA5, 6'h3F, 3'd6, 0, 0));
    vecs.push_back(mk(0, 1, pack6(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5), 1, 8'hA5, 6'h3F, 3'd6, 0, 0));
    vecs.push_back(mk(0, 1, pack6(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00), 1, 8'hA5, 6'h3F, 3'd6, 0, 0));
    vecs.push_back(mk(0, 1, pack6(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00), 1, 8'hA5, 6'h1F, 3'd5, 1, 0));
    vecs.push_back(mk(0, 0, pack6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 0, 8'hA5, 6'h1F, 3'd5, 0, 0));
`else
    vecs.push_back(mk(0, 1, pack6(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5), 1, 8'hA5, 6'h3F, 3'd6, 0, 0));
    vecs.push_back(mk(0, 1, pack6(8'hA5, 8'hA5, 8'h5A, 8'hA5, 8'hA5, 8'hA5), 1, 8'hA5, 6'h3B, 3'd5, 1, 0));
    vecs.push_back(mk(0, 1, pack6(8'h3C, 8'h3C, 8'hFF, 8'h3C, 8'h3C, 8'h3C), 1, 8'h3C, 6'h3B, 3'd5, 0, 0));
    vecs.push_back(mk(0, 0, pack6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 0, 8'h3C, 6'h3B, 3'd5, 0, 0));
    vecs.push_back(mk(0, 1, pack6(8'h00, 8'h77, 8'h77, 8'h77, 8'h77, 8'h77), 1, 8'h77, 6'h3A, 3'd4, 1, 0));
    vecs.push_back(mk(0, 1, pack6(8'h66, 8'h66, 8'h66, 8'h66, 8'hE6, 8'h66), 1, 8'h66, 6'h2A, 3'd3, 1, 1));
    vecs.push_back(mk(0, 1, pack6(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1, 8'h00, 6'h2A, 3'd3, 0, 1));
    vecs.push_back(mk(1, 1, pack6(8'h11, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11), 1, 8'h11, 6'h3F, 3'd6, 0, 0));
    vecs.push_back(mk(0, 1, pack6(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20), 1, 8'h00, 6'h00, 3'd0, 1, 1));
    vecs.push_back(mk(1, 0, pack6(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 0, 8'h00, 6'h3F, 3'd6, 0, 0));
    vecs.push_back(mk(0, 1, pack6(8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A), 1, 8'h5A, 6'h3F, 3'd6, 0, 0));
    vecs.push_back(mk(0, 1, pack6(8'hC3, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h00), 1, 8'h5A, 6'h1E, 3'd4, 1, 0));
    vecs.push_back(mk(0, 0, pack6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 0, 8'h5A, 6'h1E, 3'd4, 0, 0));
`endif

    repeat (2) @(posedge clk);
    #1;
    check_outputs(-1, 0, 8'h00, 6'h3F, 3'd6, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Push one more sample so out_valid is high, then assert reset between edges.
    @(negedge clk);
    arm      = 1'b0;
    in_valid = 1'b1;
    rep_data = pack6(8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33);
    @(posedge clk);
    #1;
    check_outputs(100, 1, 8'h33, active_mask_before_reset(), cnt_before_reset(), 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs(101, 0, 8'h00, 6'h3F, 3'd6, 0, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs(102, 0, 8'h00, 6'h3F, 3'd6, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Mask/count left by the last table vector; an all-agreeing sample changes neither.
  function automatic logic [N-1:0] active_mask_before_reset();
    return vecs[vecs.size()-1].mask;
  endfunction

  function automatic logic [CW-1:0] cnt_before_reset();
    return vecs[vecs.size()-1].cnt;
  endfunction

endmodule
